otter_mem_unaligned: RTL and testbench
======================================

// Module: otter_mem_unaligned
// PURPOSE
//  Byte-addressable dual-port OTTER main memory, successor to the byte-lane memory.
//  Port 1 is an instruction read port and port 2 a data read/write port.
//  Port 2 supports sb/sh/sw and lb/lh/lw/lbu/lhu at any byte offset, including halfwords and words that span two words.
//  A spanning access becomes a two-cycle split transaction with a busy/valid handshake. The MMIO window is routed to IO_IN/IO_WR.
// PARAMETERS
//  ACTUAL_WIDTH  14            word-address bits (2**14 x 32b = 64KB)
//  IO_BASE       32'h11000000  MEM_ADDR2 >= IO_BASE is MMIO, never touches RAM
//  ALLOW_SPLIT   1             1: split spanning accesses; 0: spanning access raises ERR, no effect
// PORTS
//  MEM_CLK     in   1   sole clock, all state on rising edge
//  RST         in   1   synchronous, active-high reset
//  MEM_ADDR1   in   32  instruction byte address (word aligned)
//  MEM_READ1   in   1   instruction read enable
//  MEM_DOUT1   out  32  instruction word, 1 cycle after MEM_READ1
//  MEM_ADDR2   in   32  data byte address
//  MEM_DIN2    in   32  store data, LSB-justified
//  MEM_READ2   in   1   load request
//  MEM_WRITE2  in   1   store request (READ2 and WRITE2 both high: WRITE2 wins)
//  MEM_SIZE    in   2   0 byte, 1 half, 2 word, 3 illegal (ERR)
//  MEM_SIGN    in   1   1 = zero-extend (lbu/lhu)
//  MEM_BUSY2   out  1   port 2 cannot accept; requester holds request inputs stable
//  MEM_VALID2  out  1   MEM_DOUT2 holds a completed load, one-cycle pulse
//  MEM_DOUT2   out  32  sign/zero-extended load data, or buffered IO_IN for MMIO
//  IO_IN       in   32  MMIO read data
//  IO_WR       out  1   MMIO store strobe, combinational, same cycle as acceptance
//  ERR         out  1   registered, pulses with completion; out of range, size 3, MEM_ADDR1[1:0]!=0, or split with ALLOW_SPLIT=0
// BEHAVIOUR
//  Reset values: MEM_DOUT1=0, MEM_DOUT2=0, MEM_BUSY2=0, MEM_VALID2=0, ERR=0, IO_WR=0, FSM=IDLE.
//  Reset does not clear the RAM array.
//  Acceptance: a request is accepted when (READ2|WRITE2) & !MEM_BUSY2. Requests seen while busy are ignored.
//  Spanning access: offset + size bytes > 4, i.e. half at offset 3, or word at offset 1..3.
//  FSM IDLE:
//   - Accepted non-spanning access: RAM word A read/written this edge. VALID2 (loads) and ERR are asserted next cycle. Stay in IDLE.
//   - Accepted spanning access: write the low bytes to word A, read word A, capture the request. Go to SPLIT with BUSY2=1.
//  FSM SPLIT:
//   - Write the high bytes to word A+1 and read word A+1. Go to IDLE.
//   - Loads: next cycle VALID2=1 with the two words merged, offset-shifted and extended.
//   - Spanning load latency is 2 cycles; aligned load latency is 1 cycle.
//  Port 1 is independent of port 2 and never stalled.
//   - Same-cycle port-1 read of a word port 2 writes returns the old word (read-first).
//  Store lanes: byte k of MEM_DIN2 goes to memory byte address MEM_ADDR2+k, little-endian, k < size bytes.
//   - Other bytes are unchanged.
//  Load extend: MEM_SIGN=0 sign-extends from bit 8*n-1; MEM_SIGN=1 zero-extends.
//  MMIO (addr >= IO_BASE):
//   - Always single-cycle, never split, no RAM effect.
//   - IO_WR=WRITE2 & !BUSY2.
//   - Load returns the full 32-bit IO_IN sampled at acceptance, no slicing.
//  Error cases (no RAM write, VALID2 still pulses for loads with DOUT2=0):
//   - word A+1 beyond 2**ACTUAL_WIDTH-1 (top wrap)
//   - any request with ERR cause
//  Reset during SPLIT: returns to IDLE. The word A+1 write is not performed, no VALID2. The word A write is already committed.
// STRUCTURE
//  Package otter_mem_pkg:
//   - mem_size_t enum {SZ_BYTE, SZ_HALF, SZ_WORD}
//   - FSM state enum {IDLE, SPLIT}
//   - IO_BASE default, lane-mask function
//  Sub-module otter_mem_align: combinational.
//   - Store side: byte-enable mask and data rotate for word A/A+1 from offset and size.
//   - Load side: 64-bit {A+1,A} merge, shift and extend.
//  Top: RAM array, FSM, request capture registers, MMIO decode.
// TESTING
//  sw 0xDEADBEEF @0x100, lw @0x100 -> VALID2 after 1 cycle, DOUT2=0xDEADBEEF, BUSY2 never high.
//  sb 0x80 @0x203, lb @0x203 -> DOUT2=0xFFFFFF80; lbu @0x203 -> 0x00000080; other bytes of word 0x200 unchanged.
//  sw 0x11223344 @0x301 -> BUSY2 high 1 cycle; lw @0x300=0x223344xx, lw @0x304=0xxxxxxx11; lw @0x301 -> 2-cycle latency, DOUT2=0x11223344.
//  lh @0x3FF with word 0x3FC=0xAB000000, 0x400=0x000000CD -> DOUT2=0xFFFFCDAB.
//  sw @IO_BASE with WRITE2=1 -> IO_WR=1 same cycle, RAM unchanged; lw @IO_BASE+4, IO_IN=0x5A5A -> DOUT2=0x5A5A.
//  RST during SPLIT of sw @0x501 -> word 0x504 unchanged, BUSY2=0 and VALID2=0 next cycle; sw @0xFFFD -> ERR, no writes.

Source files
------------

// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the unaligned OTTER memory.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package otter_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } mem_state_t;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

   // Byte lanes touched by an access of the given size, before offset shift.
   function automatic logic [3:0] lane_mask(input logic [1:0] size);
      case (mem_size_t'(size))
         SZ_BYTE: lane_mask = 4'b0001;
         SZ_HALF: lane_mask = 4'b0011;
         SZ_WORD: lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
   endfunction

   // Number of bytes in an access of the given size (0 for the illegal code).
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (mem_size_t'(size))
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         SZ_WORD: size_bytes = 3'd4;
         default: size_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/otter_mem_align.sv
// Byte-lane steering: store enables/data for words A and A+1, load merge and extend.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are used.
module otter_mem_align
   import otter_mem_pkg::*;
(
   input  logic [1:0]  i_off,
   input  logic [1:0]  i_size,
   input  logic        i_zext,
   input  logic [31:0] i_din,
   input  logic [31:0] i_rd_lo,
   input  logic [31:0] i_rd_hi,
   output logic [3:0]  o_be_lo,
   output logic [3:0]  o_be_hi,
   output logic [31:0] o_wdat_lo,
   output logic [31:0] o_wdat_hi,
   output logic [31:0] o_load
);

   logic [7:0]  w_mask;
   logic [63:0] w_wdat;
   logic [31:0] w_shift;

   // Treat {A+1, A} as one 64-bit little-endian window and shift by the byte offset.
   always_comb begin
      w_mask  = {4'b0000, lane_mask(i_size)} << i_off;
      w_wdat  = {32'h0, i_din} << {i_off, 3'b000};
      w_shift = 32'({i_rd_hi, i_rd_lo} >> {i_off, 3'b000});

      o_be_lo   = w_mask[3:0];
      o_be_hi   = w_mask[7:4];
      o_wdat_lo = w_wdat[31:0];
      o_wdat_hi = w_wdat[63:32];

      case (mem_size_t'(i_size))
         SZ_BYTE: o_load = i_zext ? {24'h0, w_shift[7:0]}
                                  : {{24{w_shift[7]}}, w_shift[7:0]};
         SZ_HALF: o_load = i_zext ? {16'h0, w_shift[15:0]}
                                  : {{16{w_shift[15]}}, w_shift[15:0]};
         default: o_load = w_shift;
      endcase
   end

endmodule

// File: rtl/otter_mem_unaligned.sv
// Dual-port OTTER main memory: instruction read port 1, unaligned data port 2, MMIO window.
// Latency: port 1 and non-spanning port 2 loads 1 cycle; spanning port 2 loads 2 cycles.
// Backpressure: MEM_BUSY2 high for the second half of a split access; requests then are ignored.
module otter_mem_unaligned
   import otter_mem_pkg::*;
#(
   parameter int          ACTUAL_WIDTH = 14,
   parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
   parameter bit          ALLOW_SPLIT  = 1'b1
) (
   input  logic        MEM_CLK,
   input  logic        RST,
   input  logic [31:0] MEM_ADDR1,
   input  logic        MEM_READ1,
   output logic [31:0] MEM_DOUT1,
   input  logic [31:0] MEM_ADDR2,
   input  logic [31:0] MEM_DIN2,
   input  logic        MEM_READ2,
   input  logic        MEM_WRITE2,
   input  logic [1:0]  MEM_SIZE,
   input  logic        MEM_SIGN,
   output logic        MEM_BUSY2,
   output logic        MEM_VALID2,
   output logic [31:0] MEM_DOUT2,
   input  logic [31:0] IO_IN,
   output logic        IO_WR,
   output logic        ERR
);

   localparam int AW = ACTUAL_WIDTH;

   logic [31:0] r_mem [0:(1<<AW)-1];

   mem_state_t  r_state, w_next;
   logic [AW-1:0] r_wa;
   logic [1:0]  r_off, r_size;
   logic        r_zext, r_wr;
   logic [31:0] r_din, r_lo;
   logic [31:0] r_dout1, r_dout2;
   logic        r_valid2, r_err;

   logic          w_busy, w_accept, w_is_io, w_oor, w_sz_bad, w_span, w_wrap;
   logic          w_err1, w_err2, w_we;
   logic [AW-1:0] w_wa, w_wa1, w_waddr;
   logic [1:0]    w_off;
   logic [2:0]    w_nb;
   logic [1:0]    w_a_off, w_a_size;
   logic          w_a_zext;
   logic [31:0]   w_a_din, w_rd_lo, w_rd_hi;
   logic [3:0]    w_be_lo, w_be_hi, w_be;
   logic [31:0]   w_wdat_lo, w_wdat_hi, w_wdat, w_load;

   // Request decode for port 2 and fault detection for both ports.
   assign w_busy   = (r_state == SPLIT);
   assign w_accept = (MEM_READ2 | MEM_WRITE2) & ~w_busy & ~RST;
   assign w_is_io  = (MEM_ADDR2 >= IO_BASE);
   assign w_wa     = MEM_ADDR2[AW+1:2];
   assign w_wa1    = r_wa + AW'(1);
   assign w_off    = MEM_ADDR2[1:0];
   assign w_nb     = size_bytes(MEM_SIZE);
   assign w_sz_bad = (MEM_SIZE == 2'd3);
   assign w_oor    = ~w_is_io & (MEM_ADDR2[31:AW+2] != '0);
   assign w_span   = ~w_is_io & ~w_sz_bad & (({1'b0, w_off} + w_nb) > 3'd4);
   assign w_wrap   = w_span & (&w_wa);
   assign w_err2   = w_sz_bad | w_oor | w_wrap | (w_span & ~ALLOW_SPLIT);
   assign w_err1   = MEM_READ1 & ((MEM_ADDR1[1:0] != 2'b00) | (MEM_ADDR1[31:AW+2] != '0));

   // The second half of a split works from the captured request, not the live inputs.
   assign w_a_off  = w_busy ? r_off  : w_off;
   assign w_a_size = w_busy ? r_size : MEM_SIZE;
   assign w_a_zext = w_busy ? r_zext : MEM_SIGN;
   assign w_a_din  = w_busy ? r_din  : MEM_DIN2;
   assign w_rd_lo  = w_busy ? r_lo   : r_mem[w_wa];
   assign w_rd_hi  = w_busy ? r_mem[w_wa1] : 32'h0;

   otter_mem_align u_align (
      .i_off     (w_a_off),
      .i_size    (w_a_size),
      .i_zext    (w_a_zext),
      .i_din     (w_a_din),
      .i_rd_lo   (w_rd_lo),
      .i_rd_hi   (w_rd_hi),
      .o_be_lo   (w_be_lo),
      .o_be_hi   (w_be_hi),
      .o_wdat_lo (w_wdat_lo),
      .o_wdat_hi (w_wdat_hi),
      .o_load    (w_load)
   );

   // FSM state register.
   always_ff @(posedge MEM_CLK) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next state and RAM write port selection: word A from IDLE, word A+1 from SPLIT.
   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_waddr = w_wa;
      w_be    = w_be_lo;
      w_wdat  = w_wdat_lo;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_is_io && !w_err2) begin
               w_we = MEM_WRITE2;
               if (w_span) w_next = SPLIT;
            end
         end
         SPLIT: begin
            w_next  = IDLE;
            w_waddr = w_wa1;
            w_be    = w_be_hi;
            w_wdat  = w_wdat_hi;
            w_we    = r_wr & ~RST;
         end
         default: w_next = IDLE;
      endcase
   end

   // RAM array: byte-enabled write, never cleared by reset.
   always_ff @(posedge MEM_CLK) begin
      if (w_we) begin
         for (int k = 0; k < 4; k++) begin
            if (w_be[k]) r_mem[w_waddr][8*k +: 8] <= w_wdat[8*k +: 8];
         end
      end
   end

   // Port 1 read, port 2 completion/capture and error reporting.
   always_ff @(posedge MEM_CLK) begin
      if (RST) begin
         r_dout1  <= 32'h0;
         r_dout2  <= 32'h0;
         r_valid2 <= 1'b0;
         r_err    <= 1'b0;
         r_wa     <= '0;
         r_off    <= 2'b00;
         r_size   <= 2'b00;
         r_zext   <= 1'b0;
         r_wr     <= 1'b0;
         r_din    <= 32'h0;
         r_lo     <= 32'h0;
      end else begin
         if (MEM_READ1) r_dout1 <= w_err1 ? 32'h0 : r_mem[MEM_ADDR1[AW+1:2]];
         r_valid2 <= 1'b0;
         r_err    <= w_err1;
         if (w_busy) begin
            if (!r_wr) begin
               r_valid2 <= 1'b1;
               r_dout2  <= w_load;
            end
         end else if (w_accept) begin
            if (w_err2) begin
               r_err <= 1'b1;
               if (!MEM_WRITE2) begin
                  r_valid2 <= 1'b1;
                  r_dout2  <= 32'h0;
               end
            end else if (w_is_io) begin
               if (!MEM_WRITE2) begin
                  r_valid2 <= 1'b1;
                  r_dout2  <= IO_IN;
               end
            end else if (w_span) begin
               r_wa   <= w_wa;
               r_off  <= w_off;
               r_size <= MEM_SIZE;
               r_zext <= MEM_SIGN;
               r_wr   <= MEM_WRITE2;
               r_din  <= MEM_DIN2;
               r_lo   <= w_rd_lo;
            end else if (!MEM_WRITE2) begin
               r_valid2 <= 1'b1;
               r_dout2  <= w_load;
            end
         end
      end
   end

   assign MEM_DOUT1  = r_dout1;
   assign MEM_DOUT2  = r_dout2;
   assign MEM_VALID2 = r_valid2;
   assign MEM_BUSY2  = w_busy;
   assign ERR        = r_err;
   assign IO_WR      = w_accept & MEM_WRITE2 & w_is_io;

endmodule

// File: tb/tb_otter_mem_unaligned.sv
// Bench for otter_mem_unaligned: directed vector table, hand sequences, random vs byte model.
// Latency: measured per request in cycles after acceptance.
// Backpressure: requests are dropped after the accepting edge; BUSY2 cycles are counted.
module tb_otter_mem_unaligned;

   localparam logic [31:0] IOB = 32'h1100_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr1, dout1, addr2, din2, dout2, io_in;
   logic        read1, read2, write2, sign, busy2, valid2, io_wr, err;
   logic [1:0]  size;

   int errors = 0;
   int checks = 0;

   logic [7:0] ref_mem [0:65535];

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] din;
      logic [1:0]  size;
      bit          zext;
      logic [31:0] exp_dout;
      int          exp_lat;
      bit          exp_err;
      int          exp_busy;
   } vec_t;

   vec_t vq[$];

   always #5 clk = ~clk;

   otter_mem_unaligned dut (
      .MEM_CLK    (clk),
      .RST        (rst),
      .MEM_ADDR1  (addr1),
      .MEM_READ1  (read1),
      .MEM_DOUT1  (dout1),
      .MEM_ADDR2  (addr2),
      .MEM_DIN2   (din2),
      .MEM_READ2  (read2),
      .MEM_WRITE2 (write2),
      .MEM_SIZE   (size),
      .MEM_SIGN   (sign),
      .MEM_BUSY2  (busy2),
      .MEM_VALID2 (valid2),
      .MEM_DOUT2  (dout2),
      .IO_IN      (io_in),
      .IO_WR      (io_wr),
      .ERR        (err)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit zx, input logic [31:0] ed,
                      input int el, input bit ee, input int eb);
      vec_t v;
      v.wr = wr; v.addr = a; v.din = d; v.size = sz; v.zext = zx;
      v.exp_dout = ed; v.exp_lat = el; v.exp_err = ee; v.exp_busy = eb;
      vq.push_back(v);
   endtask

   // One port-2 request: present it, drop it after the accepting edge, observe 3 cycles.
   task automatic op(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input bit zx,
                     output logic [31:0] got_dout, output int lat, output bit got_err,
                     output int nbusy);
      got_dout = 32'h0; lat = 0; got_err = 1'b0; nbusy = 0;
      @(negedge clk);
      read2 = ~wr; write2 = wr; addr2 = a; din2 = d; size = sz; sign = zx;
      for (int n = 1; n <= 3; n++) begin
         @(negedge clk);
         if (n == 1) begin read2 = 1'b0; write2 = 1'b0; end
         if (busy2) nbusy++;
         if (err) got_err = 1'b1;
         if (valid2 && lat == 0) begin lat = n; got_dout = dout2; end
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   // Reference load: gather bytes little-endian, then extend.
   function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit zx);
      logic [31:0] v = 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[int'(a[15:0]) + k];
      if (!zx && n < 4 && v[8*n-1]) begin
         for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      end
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int lat, nb;
      bit e;

      // Reset with a pending MMIO store to show IO_WR is held low.
      rst = 1'b1; addr1 = 32'h0; read1 = 1'b0; addr2 = IOB; din2 = 32'h0;
      read2 = 1'b0; write2 = 1'b1; size = 2'd2; sign = 1'b0; io_in = 32'h0000_5A5A;
      repeat (2) @(negedge clk);
      check("rst_io_wr", {31'h0, io_wr}, 32'h0);
      check("rst_dout1", dout1, 32'h0);
      check("rst_dout2", dout2, 32'h0);
      check("rst_busy2", {31'h0, busy2}, 32'h0);
      check("rst_valid2", {31'h0, valid2}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      write2 = 1'b0; rst = 1'b0;

      //  wr  addr          din           sz zx exp_dout      lat err busy
      add(1, 32'h100,      32'hDEADBEEF, 2, 0, 32'h0,         0, 0, 0);
      add(0, 32'h100,      32'h0,        2, 0, 32'hDEADBEEF,  1, 0, 0);
      add(1, 32'h200,      32'h01020304, 2, 0, 32'h0,         0, 0, 0);
      add(1, 32'h203,      32'h00000080, 0, 0, 32'h0,         0, 0, 0);
      add(0, 32'h203,      32'h0,        0, 0, 32'hFFFFFF80,  1, 0, 0);
      add(0, 32'h203,      32'h0,        0, 1, 32'h00000080,  1, 0, 0);
      add(0, 32'h200,      32'h0,        2, 0, 32'h80020304,  1, 0, 0);
      add(0, 32'h202,      32'h0,        1, 0, 32'hFFFF8002,  1, 0, 0);
      add(0, 32'h202,      32'h0,        1, 1, 32'h00008002,  1, 0, 0);
      add(0, 32'h201,      32'h0,        0, 0, 32'h00000003,  1, 0, 0);
      add(1, 32'h300,      32'hAAAAAAAA, 2, 0, 32'h0,         0, 0, 0);
      add(1, 32'h304,      32'hBBBBBBBB, 2, 0, 32'h0,         0, 0, 0);
      add(1, 32'h301,      32'h11223344, 2, 0, 32'h0,         0, 0, 1);
      add(0, 32'h300,      32'h0,        2, 0, 32'h223344AA,  1, 0, 0);
      add(0, 32'h304,      32'h0,        2, 0, 32'hBBBBBB11,  1, 0, 0);
      add(0, 32'h301,      32'h0,        2, 0, 32'h11223344,  2, 0, 1);
      add(1, 32'h3FC,      32'hAB000000, 2, 0, 32'h0,         0, 0, 0);
      add(1, 32'h400,      32'h000000CD, 2, 0, 32'h0,         0, 0, 0);
      add(0, 32'h3FF,      32'h0,        1, 0, 32'hFFFFCDAB,  2, 0, 1);
      add(0, 32'h3FF,      32'h0,        1, 1, 32'h0000CDAB,  2, 0, 1);
      add(0, 32'h100,      32'h0,        3, 0, 32'h0,         1, 1, 0);
      add(0, 32'h0010_0000, 32'h0,       2, 0, 32'h0,         1, 1, 0);
      add(1, 32'hFFFC,     32'h12345678, 2, 0, 32'h0,         0, 0, 0);
      add(1, 32'hFFFD,     32'hCAFEF00D, 2, 0, 32'h0,         0, 1, 0);
      add(0, 32'hFFFC,     32'h0,        2, 0, 32'h12345678,  1, 0, 0);
      add(0, IOB + 32'h4,  32'h0,        2, 0, 32'h00005A5A,  1, 0, 0);
      add(1, 32'h203,      32'h0000BEEF, 1, 0, 32'h0,         0, 0, 1);
      add(0, 32'h200,      32'h0,        2, 0, 32'hEF020304,  1, 0, 0);
      add(0, 32'h203,      32'h0,        1, 1, 32'h0000BEEF,  2, 0, 1);

      foreach (vq[i]) begin
         op(vq[i].wr, vq[i].addr, vq[i].din, vq[i].size, vq[i].zext, d, lat, e, nb);
         check($sformatf("vec%0d_lat", i), lat, vq[i].exp_lat);
         check($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vq[i].exp_err});
         check($sformatf("vec%0d_busy", i), nb, vq[i].exp_busy);
         if (vq[i].exp_lat != 0) check($sformatf("vec%0d_dout", i), d, vq[i].exp_dout);
      end

      // MMIO store: strobe in the accepting cycle, RAM word 0 untouched.
      op(1, 32'h0, 32'h55555555, 2, 0, d, lat, e, nb);
      @(negedge clk);
      write2 = 1'b1; addr2 = IOB; din2 = 32'h77; size = 2'd2;
      #1 check("io_wr_mmio", {31'h0, io_wr}, 32'h1);
      @(negedge clk);
      write2 = 1'b0;
      #1 check("io_wr_idle", {31'h0, io_wr}, 32'h0);
      op(0, 32'h0, 32'h0, 2, 0, d, lat, e, nb);
      check("io_ram_untouched", d, 32'h55555555);
      @(negedge clk);
      write2 = 1'b1; addr2 = 32'h600; din2 = 32'h1; size = 2'd2;
      #1 check("io_wr_ram_store", {31'h0, io_wr}, 32'h0);
      @(negedge clk);
      write2 = 1'b0;

      // Port 1: read-first against a same-cycle port-2 store, then misalignment error.
      @(negedge clk);
      read1 = 1'b1; addr1 = 32'h100;
      write2 = 1'b1; addr2 = 32'h100; din2 = 32'h0BADF00D; size = 2'd2;
      @(negedge clk);
      write2 = 1'b0;
      check("p1_read_first", dout1, 32'hDEADBEEF);
      @(negedge clk);
      check("p1_new_word", dout1, 32'h0BADF00D);
      addr1 = 32'h102;
      @(negedge clk);
      check("p1_misalign_err", {31'h0, err}, 32'h1);
      read1 = 1'b0; addr1 = 32'h100;
      @(negedge clk);
      check("p1_err_clears", {31'h0, err}, 32'h0);

      // Reset during SPLIT: word A committed, word A+1 untouched.
      op(1, 32'h500, 32'hAAAAAAAA, 2, 0, d, lat, e, nb);
      op(1, 32'h504, 32'hBBBBBBBB, 2, 0, d, lat, e, nb);
      @(negedge clk);
      write2 = 1'b1; addr2 = 32'h501; din2 = 32'h11223344; size = 2'd2;
      @(negedge clk);
      check("split_busy", {31'h0, busy2}, 32'h1);
      write2 = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rst_split_busy", {31'h0, busy2}, 32'h0);
      check("rst_split_valid", {31'h0, valid2}, 32'h0);
      rst = 1'b0;
      op(0, 32'h504, 32'h0, 2, 0, d, lat, e, nb);
      check("rst_split_hi", d, 32'hBBBBBBBB);
      op(0, 32'h500, 32'h0, 2, 0, d, lat, e, nb);
      check("rst_split_lo", d, 32'h223344AA);

      // Random traffic in 0x1000..0x103F against the byte model.
      for (int w = 0; w < 16; w++) begin
         logic [31:0] a, v;
         a = 32'h1000 + 32'(4*w);
         v = $urandom;
         op(1, a, v, 2, 0, d, lat, e, nb);
         for (int k = 0; k < 4; k++) ref_mem[int'(a[15:0]) + k] = v[8*k +: 8];
      end
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a, v;
         logic [1:0] sz;
         bit wr, zx, spn;
         int n;
         a  = 32'h1000 + 32'($urandom_range(0, 32'h3B));
         v  = $urandom;
         sz = 2'($urandom_range(0, 2));
         wr = 1'($urandom_range(0, 1));
         zx = 1'($urandom_range(0, 1));
         n  = nbytes(sz);
         spn = (int'(a[1:0]) + n) > 4;
         op(wr, a, v, sz, zx, d, lat, e, nb);
         check($sformatf("rnd%0d_busy", i), nb, spn ? 1 : 0);
         check($sformatf("rnd%0d_err", i), {31'h0, e}, 32'h0);
         if (wr) begin
            for (int k = 0; k < n; k++) ref_mem[int'(a[15:0]) + k] = v[8*k +: 8];
            check($sformatf("rnd%0d_store_novalid", i), lat, 0);
         end else begin
            check($sformatf("rnd%0d_lat", i), lat, spn ? 2 : 1);
            check($sformatf("rnd%0d_dout", i), d, model_load(a, n, zx));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
